fb_write_arbiter: RTL
=====================

# fb_write_arbiter

Round-robin arbiter that shares the single framebuffer BRAM write port between several pixel-writing engines: character renderer, background fill, and future sprite/line engines. Each engine presents a valid/ready pixel-write stream grouped into bursts. The arbiter grants one engine at a time and forwards accepted beats to the BRAM write port through one register stage. A cycle quota stops a long background fill from starving short character writes.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8); index 0 = char renderer, 1 = background fill.
- `AW`, 19, framebuffer address width (640x480 linear).
- `DW`, 1, pixel data width.
- `MAX_BURST`, 64, maximum GRANT cycles before forced rotation when another requester is waiting (>=1).

Ports:
- `pixel_clk`  in  1  clock, rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `en`  in  1  arbitration enable; low blocks new grants only.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_last`  in  NUM_REQ  last beat of burst, qualified by valid.
- `req_addr`  in  NUM_REQ*AW  flattened addresses; requester i at [i*AW +: AW].
- `req_data`  in  NUM_REQ*DW  flattened data; requester i at [i*DW +: DW].
- `req_ready`  out  NUM_REQ  one-hot (or zero) beat accept.
- `fb_we`  out  1  BRAM write enable.
- `fb_waddr`  out  AW  BRAM write address.
- `fb_wdata`  out  DW  BRAM write data.
- `grant_active`  out  1  high while in ARB_GRANT.
- `grant_id`  out  $clog2(NUM_REQ)  current or last owner.

## Operation
- Reset values: all outputs are 0. State = ARB_IDLE. Round-robin pointer = NUM_REQ-1, so requester 0 wins first. Quota counter = 0.
- **ARB_IDLE**: if `en` and any `req_valid`, the arbiter picks the first valid requester searching from pointer+1, modulo NUM_REQ. It registers that requester as owner, loads the pointer with the owner, clears the quota counter and moves to ARB_GRANT.
- **ARB_GRANT**:
  - `req_ready[owner]` = 1 and all other ready bits = 0.
  - A beat is accepted when `req_valid[owner]` and `req_ready[owner]` are both high.
  - The quota counter increments every GRANT cycle, whether or not a beat is accepted.
- **Exit to ARB_IDLE** happens when either:
  - an accepted beat has `req_last` = 1, or
  - the counter reaches MAX_BURST-1 and some other requester has valid high. This is preemption: the owner keeps valid and its pending beat and is re-granted by normal rotation.
- Quota reached with no other requester valid: the counter resets to 0 and the owner keeps the grant.
- Owner drops valid mid-burst: the grant is held; the idle cycles still consume quota, so no deadlock can occur.
- `en` low during ARB_GRANT does not affect the current burst. The next grant waits until `en` is high.
- Requester contract: once valid is asserted, addr, data and last must stay stable until accepted. The arbiter never drops or duplicates a beat.
- Simultaneous valid on all requesters: grants rotate strictly 0,1,2,0,...
- Reset asserted mid-burst: outputs clear asynchronously and the burst is abandoned. Requesters must restart their operation.

## Timing
- `req_ready`, `grant_active` and `grant_id` are decoded from registered state only; they have no combinational path from `req_valid`.
- Grant latency: valid first seen in ARB_IDLE at cycle t → ready at t+1 → first `fb_we` at t+2.
- Write latency: beat accepted at cycle k → `fb_we`/`fb_waddr`/`fb_wdata` valid during k+1. `fb_we` is low in every cycle after a non-accepting cycle.
- Burst end at cycle k: ARB_IDLE (all ready low) at k+1, next grant at k+2. This gives exactly one bubble cycle per arbitration.
- Throughput: 1 beat/cycle within a burst. `fb_waddr` and `fb_wdata` hold their last value when `fb_we` = 0.

## Structure
- Package `fb_arb_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t`
  - `localparam` defaults for AW and DW shared with the VGA controller.
- Sub-module `rr_priority_picker` (NUM_REQ param; inputs req vector and pointer; outputs found flag and index) is purely combinational. It is reused by future requesters.
- Top level contains the FSM, owner/pointer/quota registers and the output register stage.

## Test plan
- Reset: hold `wb_rst_i` with all valid high → all outputs 0. Release → requester 0 ready 1 cycle later; first `fb_we` 2 cycles after release.
- Single burst: requester 1 sends 4 beats to addr 100..103, data 1,0,1,1, last on beat 4 → `fb_we` pulses 4 consecutive cycles with matching addr/data, then ready low for 1 cycle.
- Round-robin: all 3 requesters send 1-beat bursts continuously → `grant_id` sequence 0,1,2,0,1,2 with a 1-cycle bubble between each.
- Preemption: MAX_BURST=64, requester 1 sends a 1000-beat fill and requester 0 raises valid at beat 10 → after 64 GRANT cycles requester 0 is granted, then requester 1 resumes. Total fill writes = 1000, no gaps or duplicate addresses.
- Quota with no contention: requester 1 alone sends 200 beats → no bubble and no ready drop until last.
- `en` low during a burst from requester 2, with requester 0 waiting → requester 2 finishes its burst, requester 0 stays ungranted until `en` returns high, then is granted 1 cycle later.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and framebuffer geometry for the framebuffer write arbiter and the VGA controller.
// The enum is the arbiter FSM state. AW/DW are the default 640x480 1-bpp framebuffer port widths.
package fb_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int FB_AW = 19;
  localparam int FB_DW = 1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set bit of req_i after ptr_i, wrapping modulo NUM_REQ.
// Zero latency. It has no handshake of its own, so found_o is low when req_i is all zeros.
module rr_priority_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic                       found_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  // One spare bit holds ptr+offset before the modulo wrap.
  logic [IW:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Walk from the farthest offset down, so the nearest requester after ptr wins by overwriting.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = {1'b0, ptr_i} + (IW+1)'(off);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (|(req_i & (NUM_REQ'(1) << cand))) begin
        found_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter that shares the framebuffer BRAM write port. An accepted beat reaches fb_we one cycle later.
// Only the owner sees ready. A MAX_BURST quota forces rotation when another engine waits, and each handover costs one idle cycle.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int AW        = FB_AW,
  parameter int DW        = FB_DW,
  parameter int MAX_BURST = 64
) (
  input  logic                       pixel_clk,
  input  logic                       wb_rst_i,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fb_we,
  output logic [AW-1:0]              fb_waddr,
  output logic [DW-1:0]              fb_wdata,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int QW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [QW-1:0] QUOTA_LAST = QW'(MAX_BURST - 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [QW-1:0]     quota_q, quota_d;

  logic              fb_we_q;
  logic [AW-1:0]     fb_waddr_q;
  logic [DW-1:0]     fb_wdata_q;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] owner_mask;
  logic              owner_vld, owner_last, accept, others_vld, quota_hit;
  logic [AW-1:0]     owner_addr;
  logic [DW-1:0]     owner_data;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign owner_vld  = |(req_valid & owner_mask);
  assign owner_last = |(req_last & owner_mask);
  assign others_vld = |(req_valid & ~owner_mask);
  assign accept     = (state_q == ARB_GRANT) && owner_vld;
  assign quota_hit  = (quota_q == QUOTA_LAST);

  always_comb begin
    owner_addr = '0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_mask[i]) begin
        owner_addr = req_addr[i*AW +: AW];
        owner_data = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      quota_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      quota_q <= quota_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    quota_d = quota_q;
    case (state_q)
      ARB_IDLE: begin
        if (en && pick_found) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          quota_d = '0;
        end
      end
      ARB_GRANT: begin
        // The quota ticks even on idle cycles, so a stalled owner still yields to waiting engines.
        quota_d = quota_hit ? '0 : quota_q + QW'(1);
        if ((accept && owner_last) || (quota_hit && others_vld)) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    grant_active = 1'b0;
    if (state_q == ARB_GRANT) begin
      req_ready    = owner_mask;
      grant_active = 1'b1;
    end
  end

  assign grant_id = owner_q;

  always_ff @(posedge pixel_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fb_we_q    <= 1'b0;
      fb_waddr_q <= '0;
      fb_wdata_q <= '0;
    end else begin
      fb_we_q <= accept;
      if (accept) begin
        fb_waddr_q <= owner_addr;
        fb_wdata_q <= owner_data;
      end
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_waddr = fb_waddr_q;
  assign fb_wdata = fb_wdata_q;

endmodule
